// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the sram_like two-master arbiter: reset level, owner IDs, size codes.
package sram_like_arbiter_pkg;

  localparam logic RST_ENABLE = 1'b1;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Pointer width that stays legal for a depth-1 FIFO.
  function automatic int unsigned ptr_width(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sram_like_arbiter_if.sv
// One sram_like port: master drives the request fields, slave answers with addr_ok/data_ok/rdata.
interface sram_like_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (output req, wr, size, addr, wdata, input rdata, addr_ok, data_ok);
  modport slave  (input req, wr, size, addr, wdata, output rdata, addr_ok, data_ok);
endinterface

// File: rtl/sram_like_owner_fifo.sv
// In-order FIFO of owner IDs for accepted-but-unreturned transactions.
module sram_like_owner_fifo
  import sram_like_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   push,
  input  owner_e push_id,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output owner_e head
);

  localparam int AW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  owner_e          mem_q [DEPTH];
  owner_e          mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push_ok, pop_ok;

  function automatic logic [AW-1:0] ptr_inc(logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign pop_ok  = pop && !empty;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset == RST_ENABLE) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= OWNER_INST;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram_like slave port between inst and data masters: data priority with inst
// anti-starvation, address lock while unacknowledged, and an owner FIFO to route returns.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                clock,
  input  logic                reset,
  sram_like_arbiter_if.slave  inst_bus,
  sram_like_arbiter_if.slave  data_bus,
  sram_like_arbiter_if.master mem_bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic          lock_q, lock_d;
  owner_e        lock_owner_q, lock_owner_d;
  logic [SW-1:0] starve_q, starve_d;

  logic          sel_valid;
  owner_e        sel;
  logic          sel_req;
  logic          in_reset;
  logic          full_blk;
  logic          mem_req;
  logic          accept;
  logic          pop;
  logic          fifo_full, fifo_empty;
  owner_e        head;

  assign in_reset = (reset == RST_ENABLE);

  always_comb begin
    sel_valid = 1'b0;
    sel       = OWNER_INST;
    if (lock_q) begin
      sel_valid = 1'b1;
      sel       = lock_owner_q;
    end else if (data_bus.req && !(inst_bus.req && starve_q == SW'(STARVE_LIMIT))) begin
      sel_valid = 1'b1;
      sel       = OWNER_DATA;
    end else if (inst_bus.req) begin
      sel_valid = 1'b1;
      sel       = OWNER_INST;
    end
    sel_req = sel_valid && ((sel == OWNER_DATA) ? data_bus.req : inst_bus.req);
  end

  // Full only blocks when no slot frees up this same cycle.
  assign full_blk = fifo_full && !mem_bus.data_ok;
  assign mem_req  = sel_req && !full_blk && !in_reset;
  assign accept   = mem_req && mem_bus.addr_ok;
  assign pop      = mem_bus.data_ok && !fifo_empty && !in_reset;

  assign mem_bus.req = mem_req;
  always_comb begin
    mem_bus.wr    = 1'b0;
    mem_bus.size  = 2'd0;
    mem_bus.addr  = 32'd0;
    mem_bus.wdata = 32'd0;
    if (sel_valid) begin
      if (sel == OWNER_DATA) begin
        mem_bus.wr    = data_bus.wr;
        mem_bus.size  = data_bus.size;
        mem_bus.addr  = data_bus.addr;
        mem_bus.wdata = data_bus.wdata;
      end else begin
        mem_bus.wr    = inst_bus.wr;
        mem_bus.size  = inst_bus.size;
        mem_bus.addr  = inst_bus.addr;
        mem_bus.wdata = inst_bus.wdata;
      end
    end
  end

  assign inst_bus.addr_ok = accept && (sel == OWNER_INST);
  assign data_bus.addr_ok = accept && (sel == OWNER_DATA);
  assign inst_bus.data_ok = pop && (head == OWNER_INST);
  assign data_bus.data_ok = pop && (head == OWNER_DATA);
  assign inst_bus.rdata   = inst_bus.data_ok ? mem_bus.rdata : 32'd0;
  assign data_bus.rdata   = data_bus.data_ok ? mem_bus.rdata : 32'd0;

  always_comb begin
    lock_d       = mem_req && !mem_bus.addr_ok;
    lock_owner_d = mem_req ? sel : lock_owner_q;
    if (!inst_bus.req || (accept && sel == OWNER_INST)) begin
      starve_d = '0;
    end else if (accept && sel == OWNER_DATA && starve_q != SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset == RST_ENABLE) begin
      lock_q       <= 1'b0;
      lock_owner_q <= OWNER_INST;
      starve_q     <= '0;
    end else begin
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      starve_q     <= starve_d;
    end
  end

  sram_like_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (accept),
    .push_id (sel),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (head)
  );

  // A return with nothing outstanding means the slave broke protocol.
  a_no_orphan_return: assert property (@(posedge clock) disable iff (reset)
    !(mem_bus.data_ok && fifo_empty));

endmodule
